// File: rtl/gf13_pkg.sv
// GF(2^13) arithmetic shared by the BCH syndrome and Chien search stages.
// Field generator p(x) = x^13 + x^4 + x^3 + x + 1.
package gf13_pkg;

   localparam int GF_M = 13;
   // Low-order terms of p(x); x^13 is implied by the shift-out bit.
   localparam logic [GF_M-1:0] GF_POLY = 13'h001B;

   typedef logic [GF_M-1:0] gf13_t;

   // Multiply by alpha (x) once, folding the x^13 term back through p(x).
   function automatic gf13_t gf13_mul_alpha(input gf13_t a);
      gf13_t r;
      r = {a[GF_M-2:0], 1'b0};
      if (a[GF_M-1]) begin
         r = r ^ GF_POLY;
      end
      return r;
   endfunction

   // Multiply by alpha^j for a constant j; unrolls into a pure XOR network.
   function automatic gf13_t gf13_mul_alpha_pow(input gf13_t a, input int j);
      gf13_t r;
      r = a;
      for (int i = 0; i < j; i++) begin
         r = gf13_mul_alpha(r);
      end
      return r;
   endfunction

endpackage

// File: rtl/bch_synd_cell.sv
// One syndrome accumulator S_J evaluated by Horner's rule:
// acc <- (first ? 0 : acc * alpha^J) ^ din on every accepted bit.
module bch_synd_cell
   import gf13_pkg::*;
#(
   parameter int J = 1
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   input  logic  first,
   input  logic  din,
   output gf13_t acc_next
);

   gf13_t acc;

   // Next accumulator value; also exported so the top can capture it on the last bit.
   always_comb begin
      acc_next = (first ? gf13_t'('0) : gf13_mul_alpha_pow(acc, J)) ^ {{(GF_M-1){1'b0}}, din};
   end

   // Accumulator register: clear on reset, update on accepted bits, otherwise hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc_next;
      end
   end

endmodule

// File: rtl/bch_syndrome_calc.sv
// BCH syndrome calculator: collects N received bits (r_{N-1} first), evaluates
// S_1..S_2T over GF(2^13) and streams them out one per cycle. The unload buffer
// is separate from the accumulators so the next codeword can start immediately.
module bch_syndrome_calc
   import gf13_pkg::*;
#(
   parameter int N = 8191,
   parameter int T = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din,
   input  logic        din_valid,
   input  logic        sop,
   output logic [12:0] synd_out,
   output logic        synd_valid,
   output logic        synd_start,
   output logic        err_nonzero,
   output logic        busy
);

   localparam int          NS       = 2 * T;
   localparam int          IDX_W    = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [12:0] N_C      = 13'(N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NS - 1);

   typedef enum logic {
      IDLE,
      COLLECT
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              accept;
   logic              last;
   logic [12:0]       cnt;
   logic [12:0]       cnt_next;
   gf13_t             acc_next [NS];
   logic              err_next;
   gf13_t             synd_buf [NS];
   logic [IDX_W-1:0]  idx;
   logic              active;
   logic              err_q;

   // A bit is taken when it starts a codeword or arrives during collection.
   assign accept = din_valid & (sop | (state == COLLECT));

   // Saturating bit count; sop restarts the count at the current bit.
   always_comb begin
      cnt_next = cnt;
      if (sop) begin
         cnt_next = 13'd1;
      end else if (cnt != N_C) begin
         cnt_next = cnt + 13'd1;
      end
      last = accept & (cnt_next == N_C);
   end

   for (genvar g = 0; g < NS; g++) begin : g_cell
      bch_synd_cell #(
         .J(g + 1)
      ) u_cell (
         .clk      (clk),
         .rst      (rst),
         .en       (accept),
         .first    (sop),
         .din      (din),
         .acc_next (acc_next[g])
      );
   end

   // OR-reduce of the freshly completed syndromes.
   always_comb begin
      err_next = 1'b0;
      for (int j = 0; j < NS; j++) begin
         err_next = err_next | (|acc_next[j]);
      end
   end

   // Collection FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Collection FSM next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (last) begin
               state_next = IDLE;
            end else if (din_valid & sop) begin
               state_next = COLLECT;
            end
         end
         COLLECT: begin
            if (last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Bit counter advances only on accepted bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= cnt_next;
      end
   end

   // Unload buffer captures the updated accumulators on the last-bit edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < NS; j++) begin
            synd_buf[j] <= '0;
         end
      end else if (last) begin
         for (int j = 0; j < NS; j++) begin
            synd_buf[j] <= acc_next[j];
         end
      end
   end

   // Unload sequencer: 2T consecutive symbols, then idle until the next completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active <= 1'b0;
         idx    <= '0;
         err_q  <= 1'b0;
      end else if (last) begin
         active <= 1'b1;
         idx    <= '0;
         err_q  <= err_next;
      end else if (active) begin
         if (idx == LAST_IDX) begin
            active <= 1'b0;
            idx    <= '0;
            err_q  <= 1'b0;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   // Outputs derive from reset-cleared registers, so reset zeroes them at once.
   always_comb begin
      synd_valid  = active;
      synd_start  = active & (idx == '0);
      synd_out    = active ? synd_buf[idx] : 13'd0;
      err_nonzero = active & err_q;
      busy        = (state == COLLECT);
   end

endmodule

// File: tb/tb_bch_syndrome_calc.sv
// Self-checking bench for bch_syndrome_calc with N=63, T=8.
module tb_bch_syndrome_calc;

   localparam int N  = 63;
   localparam int T  = 8;
   localparam int NS = 2 * T;

   logic        clk = 1'b0;
   logic        rst;
   logic        din;
   logic        din_valid;
   logic        sop;
   logic [12:0] synd_out;
   logic        synd_valid;
   logic        synd_start;
   logic        err_nonzero;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // alpha^k table built by plain polynomial arithmetic
   logic [12:0] apow [8191];

   // captured burst
   logic [12:0]   cap_out [NS];
   logic [NS-1:0] cap_vld;
   logic [NS-1:0] cap_st;
   logic [NS-1:0] cap_err;
   logic          cap_after;
   logic [12:0]   exp_s [NS];

   always #5 clk = ~clk;

   bch_syndrome_calc #(.N(N), .T(T)) dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_valid   (din_valid),
      .sop         (sop),
      .synd_out    (synd_out),
      .synd_valid  (synd_valid),
      .synd_start  (synd_start),
      .err_nonzero (err_nonzero),
      .busy        (busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // S_j = sum over set coefficients r_i of alpha^(i*j)
   task automatic model(input logic [N-1:0] r);
      for (int j = 1; j <= NS; j++) begin
         logic [12:0] s;
         s = '0;
         for (int i = 0; i < N; i++) begin
            if (r[i]) s = s ^ apow[(i * j) % 8191];
         end
         exp_s[j-1] = s;
      end
   endtask

   task automatic drive_bit(input logic b, input logic s);
      din       = b;
      din_valid = 1'b1;
      sop       = s;
      tick();
      din_valid = 1'b0;
      sop       = 1'b0;
   endtask

   task automatic drive_gap;
      din       = 1'($urandom);
      din_valid = 1'b0;
      sop       = 1'($urandom);
      tick();
      sop       = 1'b0;
   endtask

   // Sends r_{N-1}..r_0 with ngaps idle cycles scattered before bits 2..N.
   task automatic drive_frame(input logic [N-1:0] r, input int ngaps);
      int gp [N];
      for (int p = 0; p < N; p++) gp[p] = 0;
      for (int k = 0; k < ngaps; k++) begin
         int p;
         p = int'($urandom_range(N - 1, 1));
         gp[p] = gp[p] + 1;
      end
      for (int p = 0; p < N; p++) begin
         for (int g = 0; g < gp[p]; g++) drive_gap();
         drive_bit(r[N-1-p], p == 0);
      end
   endtask

   task automatic capture_burst;
      for (int k = 0; k < NS; k++) begin
         cap_out[k] = synd_out;
         cap_vld[k] = synd_valid;
         cap_st[k]  = synd_start;
         cap_err[k] = err_nonzero;
         tick();
      end
      cap_after = synd_valid;
   endtask

   task automatic test_reset;
      rst = 1'b1; din = 1'b0; din_valid = 1'b0; sop = 1'b0;
      tick(); tick();
      checks++;
      if ({synd_out, synd_valid, synd_start, err_nonzero, busy} !== 17'd0) begin
         errors++;
         $display("FAIL reset_hold: got out=%h v=%b s=%b e=%b busy=%b want all 0",
                  synd_out, synd_valid, synd_start, err_nonzero, busy);
      end
      #2 rst = 1'b0;
      tick();
      checks++;
      if ({synd_out, synd_valid, synd_start, err_nonzero, busy} !== 17'd0) begin
         errors++;
         $display("FAIL reset_release: got out=%h v=%b s=%b e=%b busy=%b want all 0",
                  synd_out, synd_valid, synd_start, err_nonzero, busy);
      end
   endtask

   task automatic test_all_zero;
      drive_frame('0, 0);
      capture_burst();
      for (int k = 0; k < NS; k++) begin
         checks++;
         if (cap_out[k] !== 13'h0000) begin
            errors++;
            $display("FAIL zero_S%0d: got %h want 0000", k + 1, cap_out[k]);
         end
         checks++;
         if ({cap_vld[k], cap_st[k], cap_err[k]} !== {1'b1, k == 0, 1'b0}) begin
            errors++;
            $display("FAIL zero_ctl%0d: got v/s/e=%b%b%b want 1%b0", k, cap_vld[k], cap_st[k], cap_err[k], k == 0);
         end
      end
      checks++;
      if (cap_after !== 1'b0) begin
         errors++;
         $display("FAIL zero_end: synd_valid=%b want 0", cap_after);
      end
   endtask

   task automatic test_last_bit;
      logic [N-1:0] r;
      r = '0; r[0] = 1'b1;
      drive_frame(r, 0);
      capture_burst();
      for (int k = 0; k < NS; k++) begin
         checks++;
         if (cap_out[k] !== 13'h0001) begin
            errors++;
            $display("FAIL r0_S%0d: got %h want 0001", k + 1, cap_out[k]);
         end
         checks++;
         if ({cap_vld[k], cap_st[k], cap_err[k]} !== {1'b1, k == 0, 1'b1}) begin
            errors++;
            $display("FAIL r0_ctl%0d: got v/s/e=%b%b%b want 1%b1", k, cap_vld[k], cap_st[k], cap_err[k], k == 0);
         end
      end
      checks++;
      if ({cap_after, err_nonzero} !== 2'b00) begin
         errors++;
         $display("FAIL r0_end: valid=%b err=%b want 0 0", cap_after, err_nonzero);
      end
   endtask

   task automatic test_r1;
      logic [12:0] want [NS];
      logic [N-1:0] r;
      for (int k = 0; k < 12; k++) want[k] = 13'd1 << (k + 1);
      want[12] = 13'h001B; want[13] = 13'h0036; want[14] = 13'h006C; want[15] = 13'h00D8;
      r = '0; r[1] = 1'b1;
      drive_frame(r, 0);
      capture_burst();
      for (int k = 0; k < NS; k++) begin
         checks++;
         if (cap_out[k] !== want[k] || cap_vld[k] !== 1'b1 || cap_err[k] !== 1'b1) begin
            errors++;
            $display("FAIL r1_S%0d: got %h v=%b e=%b want %h v=1 e=1", k + 1, cap_out[k], cap_vld[k], cap_err[k], want[k]);
         end
      end
   endtask

   task automatic test_gaps_restart;
      logic [N-1:0] r;
      r = '0; r[1] = 1'b1;
      // abandoned partial frame of 20 random bits
      for (int p = 0; p < 20; p++) begin
         if ($urandom_range(3, 0) == 0) drive_gap();
         drive_bit(1'($urandom), p == 0);
      end
      checks++;
      if (busy !== 1'b1 || synd_valid !== 1'b0) begin
         errors++;
         $display("FAIL partial_state: busy=%b valid=%b want 1 0", busy, synd_valid);
      end
      drive_frame(r, 5);
      checks++;
      if (synd_valid !== 1'b1 || synd_start !== 1'b1) begin
         errors++;
         $display("FAIL restart_latency: valid=%b start=%b want 1 1", synd_valid, synd_start);
      end
      model(r);
      capture_burst();
      for (int k = 0; k < NS; k++) begin
         checks++;
         if (cap_out[k] !== exp_s[k] || cap_vld[k] !== 1'b1 || cap_st[k] !== (k == 0)) begin
            errors++;
            $display("FAIL restart_S%0d: got %h v=%b s=%b want %h", k + 1, cap_out[k], cap_vld[k], cap_st[k], exp_s[k]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [N-1:0] ra;
      ra = '0; ra[0] = 1'b1;
      drive_frame(ra, 0);
      fork
         capture_burst();
         drive_frame('0, 0);
      join
      for (int k = 0; k < NS; k++) begin
         checks++;
         if (cap_out[k] !== 13'h0001 || cap_vld[k] !== 1'b1 || cap_st[k] !== (k == 0) || cap_err[k] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_a_S%0d: got %h v=%b s=%b e=%b want 0001 1 %b 1", k + 1, cap_out[k], cap_vld[k], cap_st[k], cap_err[k], k == 0);
         end
      end
      checks++;
      if (cap_after !== 1'b0) begin
         errors++;
         $display("FAIL b2b_a_end: valid=%b want 0", cap_after);
      end
      capture_burst();
      for (int k = 0; k < NS; k++) begin
         checks++;
         if (cap_out[k] !== 13'h0000 || cap_vld[k] !== 1'b1 || cap_st[k] !== (k == 0) || cap_err[k] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_b_S%0d: got %h v=%b s=%b e=%b want 0000 1 %b 0", k + 1, cap_out[k], cap_vld[k], cap_st[k], cap_err[k], k == 0);
         end
      end
      checks++;
      if (cap_after !== 1'b0) begin
         errors++;
         $display("FAIL b2b_b_end: valid=%b want 0", cap_after);
      end
   endtask

   task automatic test_random;
      for (int f = 0; f < 6; f++) begin
         logic [N-1:0] r;
         logic         e;
         r = N'({$urandom, $urandom});
         if (f == 0) r = '0;
         model(r);
         e = 1'b0;
         for (int k = 0; k < NS; k++) e = e | (exp_s[k] != 13'd0);
         drive_frame(r, int'($urandom_range(10, 0)));
         capture_burst();
         for (int k = 0; k < NS; k++) begin
            checks++;
            if (cap_out[k] !== exp_s[k] || cap_err[k] !== e || cap_st[k] !== (k == 0)) begin
               errors++;
               $display("FAIL rand%0d_S%0d: got %h e=%b s=%b want %h e=%b", f, k + 1, cap_out[k], cap_err[k], cap_st[k], exp_s[k], e);
            end
         end
      end
   endtask

   task automatic test_idle_ignore;
      logic seen;
      seen = 1'b0;
      for (int p = 0; p < 10; p++) begin
         drive_bit(1'($urandom), 1'b0);
         if (busy !== 1'b0 || synd_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignore: activity seen=%b want 0", seen);
      end
   endtask

   task automatic test_reset_mid;
      logic [N-1:0] r;
      logic         seen;
      r = '0; r[0] = 1'b1;
      drive_frame(r, 0);
      for (int k = 0; k < 7; k++) tick();
      checks++;
      if (synd_valid !== 1'b1 || synd_out !== 13'h0001) begin
         errors++;
         $display("FAIL pre_abort: valid=%b out=%h want 1 0001", synd_valid, synd_out);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({synd_out, synd_valid, synd_start, err_nonzero, busy} !== 17'd0) begin
         errors++;
         $display("FAIL abort_unload: out=%h v=%b s=%b e=%b busy=%b want all 0", synd_out, synd_valid, synd_start, err_nonzero, busy);
      end
      tick();
      #2 rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (synd_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL abort_resume: activity seen=%b want 0", seen);
      end
      // abort mid-collection
      for (int p = 0; p < 30; p++) drive_bit(1'($urandom), p == 0);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_collect: busy=%b want 0", busy);
      end
      tick();
      #2 rst = 1'b0;
      r = N'({$urandom, $urandom});
      model(r);
      drive_frame(r, 3);
      capture_burst();
      for (int k = 0; k < NS; k++) begin
         checks++;
         if (cap_out[k] !== exp_s[k] || cap_vld[k] !== 1'b1) begin
            errors++;
            $display("FAIL post_abort_S%0d: got %h v=%b want %h", k + 1, cap_out[k], cap_vld[k], exp_s[k]);
         end
      end
   endtask

   initial begin
      logic [13:0] t;
      apow[0] = 13'd1;
      for (int k = 1; k < 8191; k++) begin
         t = {apow[k-1], 1'b0};
         if (t[13]) t = t ^ 14'h201B;
         apow[k] = t[12:0];
      end
      test_reset();
      test_all_zero();
      test_last_bit();
      test_r1();
      test_idle_ignore();
      test_gaps_restart();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
